// File: rtl/mult_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace-tree multiplier.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
//
// Contents:
//   MULT_WIDTH / PROD_WIDTH - default operand and product widths.
//   rows_after / num_layers / rows_at / row_base - Wallace layer bookkeeping.
//   bw_corr_bit - Baugh-Wooley correction constant, one bit at a time.
package mult_pkg;

  localparam int MULT_WIDTH = 33;
  localparam int PROD_WIDTH = 2*MULT_WIDTH-1;

  // Row count after one layer of 3:2 compression. Each complete group of
  // three rows becomes a sum row and a carry row. One or two leftover rows
  // pass straight through to the next layer.
  function automatic int rows_after(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // Number of CSA layers needed to bring n rows down to two.
  function automatic int num_layers(input int n);
    int r;
    int k;
    r = n;
    k = 0;
    while (r > 2) begin
      r = rows_after(r);
      k++;
    end
    return k;
  endfunction

  // Number of rows that enter the given layer. Layer 0 is the raw
  // partial-product array.
  function automatic int rows_at(input int n, input int layer);
    int r;
    r = n;
    for (int k = 0; k < layer; k++) begin
      r = rows_after(r);
    end
    return r;
  endfunction

  // Index of the first row of the given layer inside the flattened row
  // store. The layers are laid out back to back.
  function automatic int row_base(input int n, input int layer);
    int base;
    base = 0;
    for (int k = 0; k < layer; k++) begin
      base += rows_at(n, k);
    end
    return base;
  endfunction

  // Baugh-Wooley correction for a w x w signed multiply. The correction is
  // 2^w + 2^(2w-1). Only the 2w-1 product bits are kept, so the 2^(2w-1)
  // term falls off the top. It is still described here so the function
  // remains correct for a full-width product.
  function automatic logic bw_corr_bit(input int w, input int pos);
    return (pos == w) || (pos == 2*w-1);
  endfunction

endpackage

// File: rtl/wallace_csa.sv
// Carry-save adder row: W full adders that compress three vectors into sum and carry.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure datapath.
//
// Ports:
//   x, y, z - W-bit input vectors in the same column alignment.
//   sum     - bitwise sum, same alignment as the inputs.
//   carry   - majority bits, already shifted one column left.
//             The carry out of the top column is dropped, so the arithmetic is mod 2^W.
import mult_pkg::*;

module wallace_csa #(
  parameter int W = PROD_WIDTH
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum = x ^ y ^ z;

  // The carry is shifted here rather than in the tree. The top-column
  // majority bit is therefore never built and never left dangling.
  // Where one input column is constant zero, the full adder collapses to a
  // half adder during synthesis.
  assign carry = {(x[W-2:0] & y[W-2:0]) |
                  (x[W-2:0] & z[W-2:0]) |
                  (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_multiplier.sv
// Pipelined signed WIDTH x WIDTH multiplier using Baugh-Wooley partial products,
// a Wallace CSA tree, and a final carry-propagate adder.
// Latency: 2 clock edges from a/b to c; throughput 1 per cycle.
// Backpressure: none; a new operand pair is taken on every edge.
//
// Ports:
//   clk - rising-edge clock.
//   rst - asynchronous, active-high reset. Clears every register, including c.
//   a   - WIDTH-bit two's-complement multiplicand.
//   b   - WIDTH-bit two's-complement multiplier.
//   c   - (2*WIDTH-1)-bit registered product, the low bits of a*b.
import mult_pkg::*;

module wallace_multiplier #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-2:0] c
);

  localparam int PW     = 2*WIDTH-1;
  // There are WIDTH partial-product rows plus one constant correction row.
  localparam int NPP    = WIDTH + 1;
  localparam int LAYERS = num_layers(NPP);
  localparam int FB     = row_base(NPP, LAYERS);
  localparam int TOTAL  = FB + 2;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    pp [NPP];
  logic [PW-1:0]    tree [TOTAL];
  logic [PW-1:0]    prod;

  // Stage 2: Baugh-Wooley partial products.
  // Row i holds a*b[i], shifted left by i. Any bit that pairs exactly one sign
  // bit with a magnitude bit carries negative weight, so it is inverted. The
  // correction row then absorbs the resulting offset. The sign x sign bit has
  // positive weight and is left as is.
  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      pp[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (a_q[j] & b_q[i]) ^ ((i == WIDTH-1) != (j == WIDTH-1));
      end
    end
    for (int k = 0; k < PW; k++) begin
      pp[WIDTH][k] = bw_corr_bit(WIDTH, k);
    end
  end

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    assign tree[i] = pp[i];
  end

  // Wallace reduction. The layers are stored back to back in tree[].
  // Layer l reads rows [IN_B, IN_B+N) and writes rows [OUT_B, OUT_B+rows_after(N)).
  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    localparam int N     = rows_at(NPP, l);
    localparam int IN_B  = row_base(NPP, l);
    localparam int OUT_B = row_base(NPP, l+1);
    localparam int G     = N / 3;
    localparam int R     = N % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      wallace_csa #(
        .W(PW)
      ) u_csa (
        .x     (tree[IN_B+3*g]),
        .y     (tree[IN_B+3*g+1]),
        .z     (tree[IN_B+3*g+2]),
        .sum   (tree[OUT_B+2*g]),
        .carry (tree[OUT_B+2*g+1])
      );
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign tree[OUT_B+2*G+r] = tree[IN_B+3*G+r];
    end
  end

  // Final carry-propagate adder over the two surviving rows. Overflow past
  // bit PW-1 is discarded, which gives the required wrap for (-2^(W-1))^2.
  assign prod = tree[FB] + tree[FB+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c   <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      c   <= prod;
    end
  end

endmodule

// File: tb/tb_wallace_multiplier.sv
// Self-checking bench for wallace_multiplier: reset, directed arithmetic
// cases, random back-to-back streaming and a mid-stream asynchronous reset.
// Expected products come from plain signed arithmetic on the operands.
module tb_wallace_multiplier;

  localparam int W  = 33;
  localparam int PW = 2*W-1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [PW-1:0] c;

  int checks;
  int failures;

  wallace_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sign-extend both operands to 66 bits, multiply exactly,
  // then keep the low 65 bits.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] xs;
    logic signed [2*W-1:0] ys;
    logic signed [2*W-1:0] p;
    xs = $signed({{W{x[W-1]}}, x});
    ys = $signed({{W{y[W-1]}}, y});
    p  = xs * ys;
    return p[PW-1:0];
  endfunction

  // Random operand with some weight on the interesting extremes.
  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = 33'h1_0000_0000;
      1:       v = 33'h1_FFFF_FFFF;
      2:       v = 33'h0_FFFF_FFFF;
      3:       v = 33'h0_0000_0001;
      default: v = {1'($urandom_range(0, 1)), $urandom()};
    endcase
    return v;
  endfunction

  task automatic test_reset();
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = rand_op();
      b = rand_op();
      @(posedge clk);
      #1;
      checks++;
      if (c !== '0) begin
        failures++;
        $display("FAIL reset_hold_pos k=%0d: c=%h expected=0", k, c);
      end
      @(negedge clk);
      checks++;
      if (c !== '0) begin
        failures++;
        $display("FAIL reset_hold_neg k=%0d: c=%h expected=0", k, c);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    xa = 33'd123456;
    xb = 33'h1_FFFF_FFFD;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    checks++;
    if (c !== '0) begin
      failures++;
      $display("FAIL reset_first_edge: c=%h expected=0", c);
    end
    @(posedge clk);
    #1;
    checks++;
    if (c !== ref_mul(xa, xb)) begin
      failures++;
      $display("FAIL reset_first_result: c=%h expected=%h", c, ref_mul(xa, xb));
    end
  endtask

  task automatic test_small_positive();
    a = 33'd19;
    b = 33'd15;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (c !== 65'd285) begin
      failures++;
      $display("FAIL small_19x15: c=%0d expected=285", c);
    end
    a = 33'd25983;
    b = 33'd641987;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (c !== 65'd16680748221) begin
      failures++;
      $display("FAIL small_25983x641987: c=%0d expected=16680748221", c);
    end
  endtask

  task automatic test_large_positive();
    logic [PW-1:0] e;
    a = 33'd9943000;
    b = 33'd3302367;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (c !== 65'd32835435081000) begin
      failures++;
      $display("FAIL large_9943000x3302367: c=%0d expected=32835435081000", c);
    end
    // 32-bit values placed in the 33-bit port are zero-extended, so both are positive.
    a = 32'hFFFF_FF3A;
    b = 32'hFF3A_FFFF;
    e = 65'(65'd4294967098 * 65'd4282056703);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (c !== e) begin
      failures++;
      $display("FAIL large_zext: c=%h expected=%h", c, e);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0]  av [4];
    logic [W-1:0]  bv [4];
    logic [PW-1:0] ev [4];
    av[0] = 33'h1_FFFF_FFFF; bv[0] = 33'd5;           ev[0] = 65'h1_FFFF_FFFF_FFFF_FFFB;
    av[1] = 33'h1_FFFF_FFF9; bv[1] = 33'h1_FFFF_FFF7; ev[1] = 65'd63;
    av[2] = 33'h1_0000_0000; bv[2] = 33'd1;           ev[2] = 65'h1_FFFF_FFFF_0000_0000;
    av[3] = 33'h1_0000_0000; bv[3] = 33'h1_0000_0000; ev[3] = 65'h1_0000_0000_0000_0000;
    for (int k = 0; k < 4; k++) begin
      a = av[k];
      b = bv[k];
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (c !== ev[k]) begin
        failures++;
        $display("FAIL signed_case%0d: c=%h expected=%h", k, c, ev[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] q [$];
    logic [PW-1:0] e;
    for (int k = 0; k <= 50; k++) begin
      if (k < 50) begin
        a = rand_op();
        b = rand_op();
      end
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (c !== e) begin
          failures++;
          $display("FAIL stream k=%0d: c=%h expected=%h", k, c, e);
        end
      end
      if (k < 50) q.push_back(ref_mul(a, b));
    end
  endtask

  task automatic test_midstream_reset();
    logic [PW-1:0] q [$];
    logic [PW-1:0] e;
    for (int k = 0; k < 16; k++) begin
      a = rand_op();
      b = rand_op();
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (c !== e) begin
          failures++;
          $display("FAIL midreset_stream k=%0d: c=%h expected=%h", k, c, e);
        end
      end
      q.push_back(ref_mul(a, b));
      if (k == 6) begin
        // Assert reset between edges: c must clear without a clock edge.
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (c !== '0) begin
          failures++;
          $display("FAIL midreset_async_clear: c=%h expected=0", c);
        end
        #2;
        rst = 1'b0;
        // The in-flight pair is lost. The next edge shows the cleared pipeline.
        q.delete();
        q.push_back('0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    #1;
    checks++;
    if (c !== '0) begin
      failures++;
      $display("FAIL reset_initial: c=%h expected=0", c);
    end
    test_reset();
    test_small_positive();
    test_large_positive();
    test_signed();
    test_back_to_back();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wallace_multiplier.md
Name: wallace_multiplier

Overview:
- Pipelined signed multiplier: two 33-bit two's-complement operands in, one 65-bit two's-complement product out.
- Partial products are reduced by a Wallace tree of carry-save adders, then summed by one final carry-propagate adder.
- Used as the datapath multiply unit; single clock domain.

Parameters:
- WIDTH, 33, operand width in bits; product width is 2*WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- a  input  WIDTH  signed multiplicand, two's complement.
- b  input  WIDTH  signed multiplier, two's complement.
- c  output  2*WIDTH-1  signed product, registered.

Behaviour:
- Reset: asynchronous and active-high. While rst=1, all pipeline registers clear to 0 and c=0.
- No handshake, no valid or ready signals. A new operand pair is accepted on every rising clk edge; throughput is 1 per cycle.
- Stage 1: a and b are captured into operand registers on a rising edge.
- Stage 2:
  - Partial products are generated from the registered operands using Baugh-Wooley signed generation: the sign-row and sign-column bits are inverted and correction constants added.
  - Wallace reduction uses full and half adders (3:2 and 2:2) layer by layer until two rows remain.
  - A final ripple or carry-lookahead adder sums the two rows.
  - The sum is registered into c.
- Latency: c reflects the a,b present at rising edge N after rising edge N+1, i.e. 2 clock edges. Values applied between edges are ignored until the next edge.
- Arithmetic: c = low 2*WIDTH-1 bits of the exact signed product a*b.
  - The only unrepresentable case is a=b=-2^32. The exact result +2^64 wraps to bit64=1, all others 0, which reads as -2^64. This is required behaviour, not an error.
- Operands narrower than WIDTH are the driver's responsibility. A 32-bit value assigned into the 33-bit port is zero-extended and therefore positive, e.g. 32'hFFFF_FF3A = +4294967098.
- Reset asserted mid-operation: in-flight results are discarded and c goes to 0 immediately, without waiting for a clock edge.
- After rst deasserts, the first valid c appears 2 edges after the first captured operands. Before that, c=0.
- No X propagation: every register is reset.

Decomposition:
- Shared package mult_pkg:
  - constant MULT_WIDTH=33 and derived PROD_WIDTH=65.
  - Baugh-Wooley correction-constant function.
- Natural sub-module: wallace_csa, a parameterised row of full adders (3 vectors in, sum and carry out), instantiated per reduction layer.
- The top module wallace_multiplier holds the partial-product generation, the layer generate loops, the final adder and the pipeline registers.

Test Plan:
- Reset check: rst=1 with any a,b and clock toggling -> c=0 continuously. Asserting rst asynchronously between edges forces c=0 at once.
- Small positive operands: a=19, b=15, rst=0 -> c=285 two edges later. Next, a=25983, b=641987 -> c=16680748221.
- Large positive operands: a=9943000, b=3302367 -> c=32835435081000. a=32'hFFFF_FF3A (zero-extended), b=32'hFF3A_FFFF -> c equals the exact unsigned-range product 4294967098*4282056703.
- Signed cases:
  - a=-1, b=5 -> c=-5.
  - a=-7, b=-9 -> c=63.
  - a=-2^32, b=1 -> c=-2^32.
  - a=b=-2^32 -> c has bit64=1 and all other bits 0.
- Back-to-back streaming: change a,b every cycle with 50 random signed pairs -> each c matches the pair applied 2 edges earlier, truncated to 65 bits, with no bubbles.
- Mid-stream reset: pulse rst for half a cycle during streaming -> c=0 immediately. After release, outputs resume correctly for operands captured post-reset only.
